// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
// Holds the sequencer state encoding, the default operand width and a counter-width helper.
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor built from gate primitives: diff = a - b - borrow_in.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    logic axb;
    logic na;
    logic naxb;
    logic t_lt;
    logic t_eq;

    xor g_axb  (axb, a, b);
    xor g_diff (diff, axb, borrow_in);

    // Borrow when a<b outright, or when a==b and a borrow is already pending.
    not g_na   (na, a);
    and g_lt   (t_lt, na, b);
    not g_naxb (naxb, axb);
    and g_eq   (t_eq, naxb, borrow_in);
    or  g_bout (borrow_out, t_lt, t_eq);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: difference = a - b - borrow_in, LSB first,
// one bit per clock, sequenced by a start/busy/done handshake.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic             fs_diff;
    logic             fs_bout;
    logic [WIDTH-1:0] res_next;

    full_subtractor u_fs (
        .a          (a_sh_q[0]),
        .b          (b_sh_q[0]),
        .borrow_in  (br_q),
        .diff       (fs_diff),
        .borrow_out (fs_bout)
    );

    // Result bits enter at the MSB so the word is aligned after WIDTH shifts.
    assign res_next = {fs_diff, res_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = SHIFT;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    res_d   = '0;
                    br_d    = borrow_in;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                end
            end
            SHIFT: begin
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                res_d  = res_next;
                br_d   = fs_bout;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    diff_d  = res_next;
                    bout_d  = fs_bout;
                    // Signed overflow only possible when operand signs differ.
                    ovf_d   = (a_msb_q != b_msb_q) && (fs_diff != a_msb_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy       = (state_q == SHIFT);
    assign done       = (state_q == DONE);
    assign difference = diff_q;
    assign borrow_out = bout_q;
    assign overflow   = ovf_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor computing difference = a - b - borrow_in, LSB first, one bit per clock.
- Built around a single full-subtractor cell plus a borrow flip-flop.
- Inverse-operation companion to the team's structural full-adder datapath.
- Used where area matters more than latency; a start/busy/done handshake lets a controller sequence it.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  minuend; captured on an accepted start.
- b  input  WIDTH  subtrahend; captured on an accepted start.
- borrow_in  input  1  initial borrow; captured on an accepted start.
- busy  output  1  high while bits are being shifted.
- done  output  1  one-cycle pulse when the result is valid.
- difference  output  WIDTH  result; held until the next completion.
- borrow_out  output  1  final borrow, i.e. unsigned a < b + borrow_in.
- overflow  output  1  signed overflow of a - b - borrow_in.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high.
- Reset, applied at any time including mid-operation:
  - State goes to IDLE and any operation in flight is discarded.
  - busy=0, done=0, difference=0, borrow_out=0, overflow=0.
  - Internal shift registers, borrow flop and counter cleared.
- FSM states IDLE, SHIFT, DONE:
  - IDLE: busy=0. On start=1 at edge E0: load A_sh=a, B_sh=b, br=borrow_in, cnt=0; latch a[WIDTH-1] and b[WIDTH-1]; go to SHIFT.
  - SHIFT: busy=1. Each edge:
    - d = A_sh[0]^B_sh[0]^br
    - br <= (~A_sh[0]&B_sh[0]) | (~(A_sh[0]^B_sh[0])&br)
    - A_sh, B_sh shift right; d enters the result shift register at its MSB; cnt++.
    - When cnt==WIDTH-1 at an edge (that edge is E0+WIDTH), go to DONE and register the outputs on that same edge.
  - DONE: busy=0, done=1 for exactly one cycle.
    - difference = result register; borrow_out = final br.
    - overflow = (a_msb != b_msb) && (difference[WIDTH-1] != a_msb).
    - Next state is IDLE, unless start=1 in this cycle: then reload as in IDLE and go straight to SHIFT (back-to-back, no bubble).
- Latency:
  - busy high for exactly WIDTH cycles after E0.
  - done high in the cycle after edge E0+WIDTH.
  - Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored; a, b and borrow_in changes during SHIFT have no effect.
- difference, borrow_out and overflow are updated only on the DONE-entering edge and hold otherwise, including across IDLE.
- Arithmetic is modulo 2^WIDTH. borrow_in=1 with a=b yields all-ones with borrow_out=1.
- No X on any output after the first reset edge.

Decomposition:
- Shared package serial_arith_pkg holds:
  - state enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - counter width function clog2 of WIDTH;
  - the default WIDTH constant.
- One natural sub-module: full_subtractor (inputs a, b, borrow_in; outputs diff, borrow_out), gate-level primitives (xor/and/or/not).
- Top level serial_subtractor contains the FSM, shift registers, counter and borrow flop.

Test Plan:
- WIDTH=8, reset, then start with a=0x5A, b=0x21, borrow_in=0 -> busy high 8 cycles; done pulses once in cycle E0+9; difference=0x39, borrow_out=0, overflow=0.
- a=0x00, b=0x01, borrow_in=0 -> difference=0xFF, borrow_out=1, overflow=0.
- a=0x80, b=0x01, borrow_in=0 -> difference=0x7F, borrow_out=0, overflow=1.
- a=0x10, b=0x0F, borrow_in=1 -> difference=0x00, borrow_out=0, overflow=0; then a=b=0x33, borrow_in=1 -> 0xFF, borrow_out=1.
- start with a=0x5A, b=0x21; re-pulse start with a=0xFF, b=0x00 at cycle E0+3 -> ignored, result 0x39. Then start again and assert rst at cycle E0+4 -> next cycle busy=0, done=0, outputs=0; no done pulse follows.
- Hold start=1 continuously with operands changing on each accepted start -> done every 9 cycles, no bubble cycle. Compare 200 random operand pairs against a behavioural model of a-b-borrow_in.
